// File: rtl/seq_multiplier_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
//   state_t : controller states (IDLE, CALC, DONE)
//   abs_val : magnitude of a w-bit operand. Returns the low w bits.
//             When sgn=1, the operand is treated as two's complement.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // The most-negative value maps to 2^(w-1), which still fits in w unsigned bits.
  function automatic logic [31:0] abs_val(input logic [31:0] v,
                                          input int unsigned w,
                                          input logic sgn);
    logic [31:0] mask;
    logic [31:0] msb_sh;
    mask   = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    msb_sh = v >> (w - 1);
    if (sgn && msb_sh[0]) begin
      return ((~v) + 32'd1) & mask;
    end
    return v & mask;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier. It handles one partial product per clock,
// in unsigned or two's-complement mode.
// The magnitudes are multiplied, and the sign is applied once when the product is registered.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand handshake (a, b, is_signed)
//   out_valid / out_ready: product handshake
//   product              : registered 2*Width-bit result, held until the next load
//   busy                 : high while partial products are being accumulated
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | accumulating one partial product per clock, busy=1
// DONE  | product presented, out_valid=1 until out_ready
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int Width = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [Width-1:0]   a,
  input  logic [Width-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*Width-1:0] product,
  output logic               busy
);

  localparam int CW = $clog2(Width) + 1;
  localparam int PW = 2 * Width;

  state_t          state;
  logic [PW-1:0]   mcand;
  logic [Width-1:0] mplier;
  logic            neg;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;

  logic [Width-1:0] a_mag;
  logic [Width-1:0] b_mag;
  logic [Width-1:0] mplier_sh;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_next;
  logic             last;

  assign a_mag = Width'(abs_val(32'(a), Width, is_signed));
  assign b_mag = Width'(abs_val(32'(b), Width, is_signed));

  // Shifting avoids a variable bit-select with a counter wider than the index.
  assign mplier_sh = mplier >> cnt;
  assign addend    = mplier_sh[0] ? (mcand << cnt) : '0;
  assign acc_next  = acc + addend;
  assign last      = (cnt == CW'(Width - 1));

  assign in_ready  = (state == IDLE);
  assign busy      = (state == CALC);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= PW'(a_mag);
            mplier <= b_mag;
            neg    <= is_signed & (a[Width-1] ^ b[Width-1]);
            acc    <= '0;
            cnt    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (last) begin
            product <= neg ? (-acc_next) : acc_next;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
